// File: rtl/spi_pkg.sv
// Shared SPI master types, mode encodings and the SCLK half-period helper.
// Imported by the engine, its tick generator and the bench.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int HALF_W = 32;

    // div_by below 2 would give a zero half-period; clamp it to one clk.
    function automatic logic [HALF_W-1:0] half_period(
        input logic [HALF_W-1:0] div_by
    );
        logic [HALF_W-1:0] h;
        h = div_by >> 1;
        if (h == '0) h = HALF_W'(1);
        return h;
    endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Front-end handshake plus SPI pad signals of the SPI master engine.
// master is the engine side, slave the command front-end / pad side.
interface spi_master_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 7
);
    import spi_pkg::*;

    logic [DIV_W-1:0]  div_by;
    logic              cpol;
    logic              cpha;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    modport master (
        input  div_by, cpol, cpha, tx_valid, tx_data, miso,
        output tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
    );

    modport slave (
        output div_by, cpol, cpha, tx_valid, tx_data, miso,
        input  tx_ready, rx_valid, rx_data, busy, sclk, mosi, cs_n
    );

endinterface

// File: rtl/spi_master_core_tick.sv
// Half-period counter: one-clk tick every h cycles while enabled.
// Held at zero while disabled, so each enable rise starts a fresh period.
module spi_sclk_tick
    import spi_pkg::*;
#(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] h,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == h - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Byte-oriented SPI master: one framed transfer per accepted request,
// SCLK derived from clk by the latched div_by half-period.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 7
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    localparam int            EW   = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);

    state_t            state, state_n;
    logic [EW-1:0]     edge_cnt, edge_n, edge_nx;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic [DATA_W-1:0] rx_sh, rx_sh_n;
    logic [DATA_W-1:0] rx_q, rx_n;
    logic [DIV_W-1:0]  h_q, h_n;
    logic              cpol_q, cpol_n;
    logic              cpha_q, cpha_n;
    logic              sclk_q, sclk_n;
    logic              mosi_q, mosi_n;
    logic              cs_q, cs_n_nx;
    logic              rxv_q, rxv_n;
    logic              tick, lead, sample;

    spi_sclk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .h    (h_q),
        .tick (tick)
    );

    assign edge_nx = edge_cnt + EW'(1);
    assign lead    = edge_nx[0];
    assign sample  = cpha_q ? !lead : lead;

    always_comb begin
        state_n = state;
        edge_n  = edge_cnt;
        tx_sh_n = tx_sh;
        rx_sh_n = rx_sh;
        rx_n    = rx_q;
        rxv_n   = 1'b0;
        h_n     = h_q;
        cpol_n  = cpol_q;
        cpha_n  = cpha_q;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        cs_n_nx = cs_q;
        unique case (state)
            IDLE: begin
                sclk_n  = bus.cpol;
                cs_n_nx = 1'b1;
                mosi_n  = 1'b0;
                if (bus.tx_valid) begin
                    state_n = LEAD;
                    edge_n  = '0;
                    rx_sh_n = '0;
                    cpol_n  = bus.cpol;
                    cpha_n  = bus.cpha;
                    h_n     = DIV_W'(half_period(HALF_W'(bus.div_by)));
                    cs_n_nx = 1'b0;
                    // cpha=0 presents the MSB before the first edge
                    if (bus.cpha) begin
                        tx_sh_n = bus.tx_data;
                    end else begin
                        mosi_n  = bus.tx_data[DATA_W-1];
                        tx_sh_n = bus.tx_data << 1;
                    end
                end
            end
            LEAD, XFER: begin
                if (tick) begin
                    edge_n  = edge_nx;
                    sclk_n  = !sclk_q;
                    state_n = (edge_nx == LAST) ? TRAIL : XFER;
                    if (sample) begin
                        rx_sh_n = {rx_sh[DATA_W-2:0], bus.miso};
                    end else if (edge_nx != LAST) begin
                        mosi_n  = tx_sh[DATA_W-1];
                        tx_sh_n = tx_sh << 1;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_n = IDLE;
                    sclk_n  = cpol_q;
                    cs_n_nx = 1'b1;
                    mosi_n  = 1'b0;
                    rx_n    = rx_sh;
                    rxv_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_q     <= '0;
            rxv_q    <= 1'b0;
            h_q      <= DIV_W'(1);
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            tx_sh    <= tx_sh_n;
            rx_sh    <= rx_sh_n;
            rx_q     <= rx_n;
            rxv_q    <= rxv_n;
            h_q      <= h_n;
            cpol_q   <= cpol_n;
            cpha_q   <= cpha_n;
            sclk_q   <= sclk_n;
            mosi_q   <= mosi_n;
            cs_q     <= cs_n_nx;
        end
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.rx_valid = rxv_q;
    assign bus.rx_data  = rx_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: framing, modes, divider limits,
// back-to-back requests, mid-frame reset and mid-frame input changes.
module tb_spi_master_core;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(8), .DIV_W(7)) bus ();

    spi_master_core #(.DATA_W(8), .DIV_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic       loop       = 1'b1;
    logic [7:0] slave_word = 8'h00;
    logic       slave_bit  = 1'b0;
    assign bus.miso = loop ? bus.mosi : slave_bit;

    int   exp_h    = 2;
    logic exp_cpha = 1'b0;

    int   cyc = 0, fe = 0, last_edge = 0, mon_idx = 0;
    int   cs_low = 0, edges = 0, space_err = 0, mosi_err = 0;
    int   rxv = 0, rdy_err = 0, busy_err = 0;
    logic sclk_p = 1'b0, mosi_p = 1'b0, cs_p = 1'b1;

    // Bus monitor and slave model, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.cs_n) begin
            fe = 0;
        end else begin
            cs_low++;
            if (cs_p) last_edge = cyc;
            if (bus.tx_ready) rdy_err++;
            if (!cs_p && bus.sclk !== sclk_p) begin
                fe++;
                edges++;
                if (cyc - last_edge != exp_h) space_err++;
                last_edge = cyc;
                if ((exp_cpha ? (fe % 2 == 0) : (fe % 2 == 1)) && bus.mosi !== mosi_p)
                    mosi_err++;
            end
        end
        if (bus.busy !== !bus.tx_ready) busy_err++;
        if (bus.rx_valid) rxv++;
        mon_idx   = exp_cpha ? (fe + 1) / 2 - 1 : fe / 2;
        slave_bit = (mon_idx >= 0 && mon_idx < 8) ? slave_word[7 - mon_idx] : 1'b0;
        sclk_p = bus.sclk;
        mosi_p = bus.mosi;
        cs_p   = bus.cs_n;
    end

    logic [7:0] r_got;
    int   r_lat, d_cs, d_edges, d_space, d_mosi, d_rxv, d_rdy;
    logic r_idle, r_after;

    task automatic run_frame(input logic [7:0] d, input logic [6:0] dv,
                             input logic [1:0] mode, input logic lb,
                             input logic [7:0] sw, input logic chg, input int h);
        int c0, e0, s0, m0, v0, r0, n;
        @(negedge clk);
        bus.div_by = dv; bus.cpol = mode[1]; bus.cpha = mode[0];
        bus.tx_data = d; loop = lb; slave_word = sw;
        exp_cpha = mode[0]; exp_h = h;
        @(negedge clk);
        r_idle = bus.sclk;
        #1;
        c0 = cs_low; e0 = edges; s0 = space_err; m0 = mosi_err; v0 = rxv; r0 = rdy_err;
        bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 100) begin @(negedge clk); n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL ready_wait n=%0d exp<100", n); end
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        if (chg) begin bus.div_by = 7'd10; bus.cpol = ~mode[1]; bus.cpha = ~mode[0]; end
        r_lat = 0;
        do begin @(negedge clk); r_lat++; end while (!bus.rx_valid && r_lat < 3000);
        r_got = bus.rx_data;
        repeat (3) @(negedge clk);
        r_after = bus.sclk;
        #1;
        d_cs = cs_low - c0; d_edges = edges - e0; d_space = space_err - s0;
        d_mosi = mosi_err - m0; d_rxv = rxv - v0; d_rdy = rdy_err - r0;
    endtask

    task automatic test_reset;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.div_by = 7'd4;
        bus.cpol = 1'b1; bus.cpha = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b exp=1", bus.cs_n); end
        total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", bus.sclk); end
        total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b exp=0", bus.mosi); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.tx_ready); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rxv got=%b exp=0", bus.rx_valid); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rst_rxd got=%h exp=00", bus.rx_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.sclk !== 1'b1) begin bad++; $display("FAIL rst_cpol got=%b exp=1", bus.sclk); end
    endtask

    task automatic test_mode0;
        run_frame(8'hA5, 7'd4, SPI_MODE0, 1'b1, 8'h00, 1'b0, 2);
        total++; if (r_got !== 8'hA5) begin bad++; $display("FAIL m0_data got=%h exp=a5", r_got); end
        total++; if (d_cs != 34) begin bad++; $display("FAIL m0_cslow got=%0d exp=34", d_cs); end
        total++; if (d_edges != 16) begin bad++; $display("FAIL m0_edges got=%0d exp=16", d_edges); end
        total++; if (d_space != 0) begin bad++; $display("FAIL m0_spacing got=%0d exp=0", d_space); end
        total++; if (d_rxv != 1) begin bad++; $display("FAIL m0_rxv got=%0d exp=1", d_rxv); end
        total++; if (r_lat != 35) begin bad++; $display("FAIL m0_lat got=%0d exp=35", r_lat); end
        total++; if (d_rdy != 0) begin bad++; $display("FAIL m0_ready got=%0d exp=0", d_rdy); end
    endtask

    task automatic test_modes;
        logic [1:0] md;
        for (int m = 1; m < 4; m++) begin
            md = 2'(m);
            run_frame(8'h3C, 7'd6, md, 1'b0, 8'hC3, 1'b0, 3);
            total++; if (r_got !== 8'hC3) begin bad++; $display("FAIL mode%0d_data got=%h exp=c3", m, r_got); end
            total++; if (r_idle !== md[1]) begin bad++; $display("FAIL mode%0d_idle got=%b exp=%b", m, r_idle, md[1]); end
            total++; if (r_after !== md[1]) begin bad++; $display("FAIL mode%0d_after got=%b exp=%b", m, r_after, md[1]); end
            total++; if (d_mosi != 0) begin bad++; $display("FAIL mode%0d_mosi got=%0d exp=0", m, d_mosi); end
            total++; if (d_edges != 16) begin bad++; $display("FAIL mode%0d_edges got=%0d exp=16", m, d_edges); end
            total++; if (d_space != 0) begin bad++; $display("FAIL mode%0d_spacing got=%0d exp=0", m, d_space); end
            total++; if (r_lat != 52) begin bad++; $display("FAIL mode%0d_lat got=%0d exp=52", m, r_lat); end
        end
    endtask

    task automatic test_div_limits;
        run_frame(8'h5A, 7'd0, SPI_MODE0, 1'b1, 8'h00, 1'b0, 1);
        total++; if (r_got !== 8'h5A) begin bad++; $display("FAIL div0_data got=%h exp=5a", r_got); end
        total++; if (r_lat != 18) begin bad++; $display("FAIL div0_frame got=%0d exp=18", r_lat); end
        total++; if (d_space != 0) begin bad++; $display("FAIL div0_spacing got=%0d exp=0", d_space); end
        run_frame(8'hE7, 7'd1, SPI_MODE1, 1'b1, 8'h00, 1'b0, 1);
        total++; if (r_got !== 8'hE7) begin bad++; $display("FAIL div1_data got=%h exp=e7", r_got); end
        total++; if (r_lat != 18) begin bad++; $display("FAIL div1_frame got=%0d exp=18", r_lat); end
        total++; if (d_cs != 17) begin bad++; $display("FAIL div1_cslow got=%0d exp=17", d_cs); end
        run_frame(8'h96, 7'd127, SPI_MODE0, 1'b1, 8'h00, 1'b0, 63);
        total++; if (r_got !== 8'h96) begin bad++; $display("FAIL div127_data got=%h exp=96", r_got); end
        total++; if (r_lat != 1072) begin bad++; $display("FAIL div127_lat got=%0d exp=1072", r_lat); end
        total++; if (d_space != 0) begin bad++; $display("FAIL div127_spacing got=%0d exp=0", d_space); end
    endtask

    task automatic test_back_to_back;
        int n, v0, r0;
        logic [7:0] g1, g2;
        @(negedge clk);
        bus.div_by = 7'd4; bus.cpol = 1'b0; bus.cpha = 1'b0;
        loop = 1'b1; exp_cpha = 1'b0; exp_h = 2;
        @(negedge clk);
        #1;
        v0 = rxv; r0 = rdy_err;
        bus.tx_data = 8'h01; bus.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus.tx_data = 8'h02;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_valid && n < 3000);
        g1 = bus.rx_data;
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL b2b_gap_hi got=%b exp=1", bus.cs_n); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.tx_ready); end
        @(negedge clk);
        total++; if (bus.cs_n !== 1'b0) begin bad++; $display("FAIL b2b_gap_len got=%b exp=0", bus.cs_n); end
        bus.tx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rx_valid && n < 3000);
        g2 = bus.rx_data;
        repeat (3) @(negedge clk);
        #1;
        total++; if (g1 !== 8'h01) begin bad++; $display("FAIL b2b_first got=%h exp=01", g1); end
        total++; if (g2 !== 8'h02) begin bad++; $display("FAIL b2b_second got=%h exp=02", g2); end
        total++; if (rxv - v0 != 2) begin bad++; $display("FAIL b2b_rxv got=%0d exp=2", rxv - v0); end
        total++; if (rdy_err - r0 != 0) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=0", rdy_err - r0); end
    endtask

    task automatic test_reset_mid;
        int n, v0;
        @(negedge clk);
        bus.div_by = 7'd4; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.tx_data = 8'hF0;
        loop = 1'b1; exp_cpha = 1'b0; exp_h = 2;
        @(negedge clk);
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        n = 0;
        while (fe < 7 && n < 200) begin @(negedge clk); #1; n++; end
        total++; if (fe != 7) begin bad++; $display("FAIL rmid_edge got=%0d exp=7", fe); end
        v0 = rxv;
        rst = 1'b1;
        #1;
        total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL rmid_cs got=%b exp=1", bus.cs_n); end
        total++; if (bus.sclk !== 1'b0) begin bad++; $display("FAIL rmid_sclk got=%b exp=0", bus.sclk); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", bus.tx_ready); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rxd got=%h exp=00", bus.rx_data); end
        bus.cpol = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.sclk !== 1'b1) begin bad++; $display("FAIL rmid_cpol got=%b exp=1", bus.sclk); end
        repeat (40) @(negedge clk);
        #1;
        total++; if (rxv != v0) begin bad++; $display("FAIL rmid_no_rxv got=%0d exp=%0d", rxv, v0); end
        run_frame(8'h81, 7'd4, SPI_MODE2, 1'b1, 8'h00, 1'b0, 2);
        total++; if (r_got !== 8'h81) begin bad++; $display("FAIL rmid_next got=%h exp=81", r_got); end
        total++; if (r_lat != 35) begin bad++; $display("FAIL rmid_lat got=%0d exp=35", r_lat); end
    endtask

    task automatic test_midframe_change;
        run_frame(8'h6D, 7'd4, SPI_MODE0, 1'b1, 8'h00, 1'b1, 2);
        total++; if (r_got !== 8'h6D) begin bad++; $display("FAIL chg_data got=%h exp=6d", r_got); end
        total++; if (r_lat != 35) begin bad++; $display("FAIL chg_lat got=%0d exp=35", r_lat); end
        total++; if (d_space != 0) begin bad++; $display("FAIL chg_spacing got=%0d exp=0", d_space); end
        total++; if (d_mosi != 0) begin bad++; $display("FAIL chg_mosi got=%0d exp=0", d_mosi); end
        run_frame(8'h2B, 7'd10, SPI_MODE3, 1'b1, 8'h00, 1'b0, 5);
        total++; if (r_got !== 8'h2B) begin bad++; $display("FAIL new_data got=%h exp=2b", r_got); end
        total++; if (r_lat != 86) begin bad++; $display("FAIL new_lat got=%0d exp=86", r_lat); end
        total++; if (d_cs != 85) begin bad++; $display("FAIL new_cslow got=%0d exp=85", d_cs); end
        total++; if (r_idle !== 1'b1) begin bad++; $display("FAIL new_idle got=%b exp=1", r_idle); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_div_limits();
        test_back_to_back();
        test_reset_mid();
        test_midframe_change();
        total++; if (busy_err != 0) begin bad++; $display("FAIL busy_mirror got=%0d exp=0", busy_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
